// File: rtl/vga_sync_if.sv
// Timing bundle from vga_sync_gen to the pixel generator and VGA connector.
// master drives counters/flags/sync; slave consumes them.
interface vga_sync_if;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        p_tick;
  logic        frame_start;

  modport master (
    output pixel_x,
    output pixel_y,
    output video_on,
    output hsync,
    output vsync,
    output p_tick,
    output frame_start
  );

  modport slave (
    input pixel_x,
    input pixel_y,
    input video_on,
    input hsync,
    input vsync,
    input p_tick,
    input frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing: clock divider, h/v counters, registered flags.
// VGA_SYNC_ALIGN_EN adds one register stage on hsync/vsync only.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master o_vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [15:0]   H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0]   V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0]   H_VIS   = 16'(H_DISPLAY);
  localparam logic [15:0]   V_VIS   = 16'(V_DISPLAY);
  localparam logic [15:0]   HS_BEG  = 16'(H_DISPLAY + H_FRONT);
  localparam logic [15:0]   HS_END  = 16'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [15:0]   VS_BEG  = 16'(V_DISPLAY + V_FRONT);
  localparam logic [15:0]   VS_END  = 16'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DW-1:0] r_div_cnt;
  logic [15:0]   r_pixel_x;
  logic [15:0]   r_pixel_y;
  logic          r_video_on;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_p_tick;
  logic          r_frame_start;

  logic          w_tick;
  logic          w_wrap;
  logic [15:0]   w_x_nxt;
  logic [15:0]   w_y_nxt;
  logic          w_video_nxt;
  logic          w_hsync_nxt;
  logic          w_vsync_nxt;

  assign w_tick = (r_div_cnt == DIV_MAX);

  // Next counter values; they move only on the tick edge.
  always_comb begin
    w_x_nxt = r_pixel_x;
    w_y_nxt = r_pixel_y;
    w_wrap  = 1'b0;
    if (w_tick) begin
      if (r_pixel_x == H_LAST) begin
        w_x_nxt = '0;
        if (r_pixel_y == V_LAST) begin
          w_y_nxt = '0;
          w_wrap  = 1'b1;
        end else begin
          w_y_nxt = r_pixel_y + 16'd1;
        end
      end else begin
        w_x_nxt = r_pixel_x + 16'd1;
      end
    end
  end

  // Flags decoded from the values being written so they never lag.
  always_comb begin
    w_video_nxt = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
    w_hsync_nxt = !((w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END));
    w_vsync_nxt = !((w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END));
  end

  // Divider, counters and registered flags; reset wins over a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_video_on    <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_p_tick      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div_cnt     <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_pixel_x     <= w_x_nxt;
      r_pixel_y     <= w_y_nxt;
      r_video_on    <= w_video_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_p_tick      <= w_tick;
      r_frame_start <= w_wrap;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic r_hsync_d;
  logic r_vsync_d;

  // Extra sync stage to line up with the pixel generator's rgb register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync_d <= 1'b1;
      r_vsync_d <= 1'b1;
    end else begin
      r_hsync_d <= r_hsync;
      r_vsync_d <= r_vsync;
    end
  end

  assign o_vga.hsync = r_hsync_d;
  assign o_vga.vsync = r_vsync_d;
`else
  assign o_vga.hsync = r_hsync;
  assign o_vga.vsync = r_vsync;
`endif

  assign o_vga.pixel_x     = r_pixel_x;
  assign o_vga.pixel_y     = r_pixel_y;
  assign o_vga.video_on    = r_video_on;
  assign o_vga.p_tick      = r_p_tick;
  assign o_vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a scaled-down raster (30x13, CLK_DIV 4).
// Model derives every output from the clk count since reset release.
module tb_vga_sync_gen;

  localparam int HD = 16, HF = 4, HS = 6, HB = 4;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 3;
  localparam int CD = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int SLAG = 1;
`else
  localparam int SLAG = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vga_sync_if vif();

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .o_vga(vif.master)
  );

  // n = number of non-reset edges since the last reset edge
  always @(posedge clk) n <= reset ? 0 : n + 1;

  function automatic void sync_at(input int k, output logic hs,
                                  output logic vs);
    int idx, x, y;
    if (k <= 0) begin
      hs = 1'b1;
      vs = 1'b1;
    end else begin
      idx = (k / CD) % (HT * VT);
      x = idx % HT;
      y = idx / HT;
      hs = !(x >= HD + HF && x < HD + HF + HS);
      vs = !(y >= VD + VF && y < VD + VF + VS);
    end
  endfunction

  function automatic void model(input int k,
      output int x, output int y, output logic von,
      output logic hs, output logic vs,
      output logic pt, output logic fs);
    int idx;
    if (k == 0) begin
      x = 0; y = 0; von = 0; pt = 0; fs = 0;
    end else begin
      idx = (k / CD) % (HT * VT);
      x = idx % HT;
      y = idx / HT;
      von = (x < HD) && (y < VD);
      pt = (k % CD) == 0;
      fs = pt && (idx == 0);
    end
    sync_at(k - SLAG, hs, vs);
    if (k == 0) begin
      hs = 1'b1;
      vs = 1'b1;
    end
  endfunction

  // Every-cycle compare against the model
  always @(negedge clk) begin
    int mx, my;
    logic mv, mh, mvs, mp, mf;
    model(n, mx, my, mv, mh, mvs, mp, mf);
    total++;
    if (vif.pixel_x !== 16'(mx) || vif.pixel_y !== 16'(my) ||
        vif.video_on !== mv || vif.hsync !== mh ||
        vif.vsync !== mvs || vif.p_tick !== mp ||
        vif.frame_start !== mf) begin
      bad++;
      $display("FAIL model n=%0d got x=%0d y=%0d v=%b h=%b vs=%b pt=%b fs=%b want x=%0d y=%0d v=%b h=%b vs=%b pt=%b fs=%b",
               n, vif.pixel_x, vif.pixel_y, vif.video_on, vif.hsync,
               vif.vsync, vif.p_tick, vif.frame_start,
               mx, my, mv, mh, mvs, mp, mf);
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  initial begin
    int t0, t1, lo, hfall, x20, vfall, y8, vfx, prev_h, prev_v, prev_o;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_x", int'(vif.pixel_x), 0);
    chk("rst_hs", int'(vif.hsync), 1);
    chk("rst_von", int'(vif.video_on), 0);
    reset = 1'b0;

    t0 = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (vif.p_tick) begin
        t0 = i;
        break;
      end
    end
    chk("first_tick_clks", t0, 4);
    chk("first_tick_x", int'(vif.pixel_x), 1);

    t0 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vif.p_tick && vif.pixel_x == 0) begin
        t0 = n;
        break;
      end
    end
    chk("line1_start", t0, 120);
    t1 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vif.p_tick && vif.pixel_x == 0) begin
        t1 = n;
        break;
      end
    end
    chk("line_period", t1 - t0, 120);

    lo = 0; hfall = -1; x20 = -1; vfx = -1;
    prev_h = vif.hsync; prev_o = vif.video_on;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!vif.hsync) lo++;
      if (vif.p_tick && vif.pixel_x == 16'(HD + HF)) x20 = n;
      if (prev_h == 1 && !vif.hsync) hfall = n;
      if (prev_o == 1 && !vif.video_on) vfx = int'(vif.pixel_x);
      prev_h = vif.hsync;
      prev_o = vif.video_on;
    end
    chk("hsync_low_clks", lo, 24);
    chk("hsync_fall_lag", hfall - x20, SLAG);
    chk("video_off_x", vfx, 16);

    lo = 0; vfall = -1; y8 = -1; t0 = -1;
    prev_v = vif.vsync;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!vif.vsync) lo++;
      if (vif.p_tick && vif.pixel_x == 0 && vif.pixel_y == 16'(VD + VF))
        y8 = n;
      if (prev_v == 1 && !vif.vsync) vfall = n;
      prev_v = vif.vsync;
      if (vif.frame_start) begin
        t0 = n;
        break;
      end
    end
    chk("frame1_at", t0, 1560);
    chk("vsync_low_clks", lo, 240);
    chk("vsync_fall_lag", vfall - y8, SLAG);
    chk("fs_xy", int'(vif.pixel_x) + int'(vif.pixel_y), 0);
    chk("fs_ptick", int'(vif.p_tick), 1);

    t1 = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (vif.frame_start) begin
        t1 = n;
        break;
      end
    end
    chk("frame_period", t1 - t0, 1560);

    t0 = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (vif.pixel_x == 16'd25 && vif.pixel_y == 16'd4) begin
        t0 = 1;
        break;
      end
    end
    chk("mid_found", t0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_x", int'(vif.pixel_x), 0);
    chk("mid_y", int'(vif.pixel_y), 0);
    chk("mid_hs", int'(vif.hsync), 1);
    chk("mid_fs", int'(vif.frame_start), 0);

    t0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vif.p_tick) begin
        t0 = 1;
        break;
      end
    end
    chk("tick_found", t0, 1);
    repeat (3) @(negedge clk);
    t1 = int'(vif.pixel_x);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("tickrst_x_before", t1, 1);
    chk("tickrst_x", int'(vif.pixel_x), 0);
    chk("tickrst_pt", int'(vif.p_tick), 0);

    repeat (200) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
